l2_issue: RTL and testbench
===========================

L2_ISSUE -- requirements
Module: l2_issue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction-queue depth in entries (power of 2, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port instr_in  input  10  instruction: [9:8] opcode, [7:6] X addr, [5:4] Y addr, [3:0] immediate data.
REQ-005 SHALL have port instr_valid  input  1  producer offers instr_in this cycle.
REQ-006 SHALL have port instr_ready  output  1  queue can accept; a transfer occurs on an edge where valid and ready are both 1.
REQ-007 SHALL have port sm_state  input  4  current state code of the downstream control state machine.
REQ-008 SHALL have port execute  output  1  go signal to the control state machine.
REQ-009 SHALL have ports operation (2), addr_x (2), addr_y (2) and data_out (4), all outputs, carrying the opcode, X address, Y address and immediate data of the issued instruction.
REQ-010 SHALL have port busy  output  1  queue non-empty or an issue is in progress.
REQ-011 SHALL have port retired  output  8  count of completed instructions.

Function
REQ-012 SHALL buffer instructions in a DEPTH-entry FIFO; instr_ready = (count < DEPTH), a function of the registered count only; when full, a push is refused even if a pop occurs on the same edge.
REQ-013 SHALL drive all outputs other than instr_ready and busy from registers.
REQ-014 SHALL implement issue FSM states I_IDLE, I_ISSUE and I_RELEASE.
REQ-015 I_IDLE->I_ISSUE SHALL occur when the queue is non-empty and sm_state==4'b0000. On that edge the head entry is loaded into operation/addr_x/addr_y/data_out and execute is set to 1.
REQ-016 Latency: an entry accepted into an empty queue at edge N SHALL raise execute at edge N+1, provided sm_state==0.
REQ-017 I_ISSUE->I_RELEASE SHALL occur when sm_state==4'b1000 (DONE). On that edge: execute<=0, the head entry is popped, retired is incremented.
REQ-018 I_RELEASE->I_IDLE SHALL occur when sm_state==4'b0000; no new issue occurs in the same cycle.
REQ-019 Instruction fields SHALL be held stable from the rise of execute until the FSM leaves I_RELEASE.
REQ-020 A simultaneous push and pop on a non-full queue SHALL leave count unchanged and preserve order.
REQ-021 retired SHALL wrap 255->0.
REQ-022 With the queue empty, execute SHALL stay 0 and the fields SHALL hold their last values.
REQ-023 busy SHALL equal (state != I_IDLE) or (count != 0).

Reset
REQ-024 When rst_n==0 at an edge, the block SHALL: empty the queue, enter I_IDLE, and set execute, operation, addr_x, addr_y, data_out and retired to 0. instr_ready SHALL read 1 in the next cycle.
REQ-025 Reset mid-issue SHALL abandon the in-flight instruction without incrementing retired. A new issue SHALL wait for sm_state==0.

Configuration
REQ-026 Macro L2_ISSUE_STEP_EN, when defined, SHALL add port step  input  1.
REQ-027 With L2_ISSUE_STEP_EN defined, the I_IDLE->I_ISSUE transition SHALL additionally require step==1 in that cycle. A step pulse seen outside I_IDLE, or with the queue empty, SHALL be ignored and not remembered.
REQ-028 With L2_ISSUE_STEP_EN undefined, the step port SHALL be absent and issue SHALL be automatic.

Structure
REQ-029 Package l2_pkg SHALL hold the following shared definitions:
- opcode constants: OP_LOAD=00, OP_MV=01, OP_SUB=10, OP_ADD=11;
- SM_IDLE=4'b0000 and SM_DONE=4'b1000;
- instruction field bit positions;
- the issue-FSM state type.
REQ-030 The queue SHALL be sub-module l2_instr_fifo (push/pop/full/empty/head/count); the issue FSM and retired counter SHALL live in l2_issue.

Verification
REQ-031 Single instruction: after reset, push 10'b11_01_10_0000 with sm_state modelled as 0->2->4->7->8->0.
- execute SHALL rise 1 cycle after acceptance, with operation=3, addr_x=1, addr_y=2.
- execute SHALL fall on the edge where sm_state==8.
- retired SHALL become 1.
REQ-032 Full queue: push 5 entries back-to-back with DEPTH=4 and sm_state held 0.
- instr_ready SHALL be 0 after the 4th acceptance.
- The 5th entry SHALL be accepted only after the first pop.
REQ-033 Order: queue LOAD d=5, MV, SUB, ADD. Issued opcodes SHALL be 0,1,2,3 in order, and data_out SHALL be 5 during the first issue.
REQ-034 Reset mid-issue: assert rst_n=0 while in I_ISSUE with 3 entries queued.
- Next cycle SHALL show execute=0, retired=0, busy=0.
- With sm_state=3 after reset, no issue SHALL occur until sm_state==0.
REQ-035 Wrap: complete 256 instructions; retired SHALL read 0.
REQ-036 With L2_ISSUE_STEP_EN defined: 2 entries queued and no step SHALL give execute=0. One step pulse SHALL issue exactly one instruction.

Source files
------------

// File: rtl/l2_pkg.sv
// -----------------------------------------------------------------------------
// l2_pkg -- shared definitions for the L2 instruction-issue block.
//   * opcode constants, downstream state-machine codes of interest
//   * instruction field bit positions and a packed instruction view
//   * issue-FSM state type
// -----------------------------------------------------------------------------
package l2_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MV   = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

  localparam logic [3:0] SM_IDLE = 4'b0000;
  localparam logic [3:0] SM_DONE = 4'b1000;

  localparam int INSTR_W = 10;
  localparam int OP_MSB  = 9;
  localparam int OP_LSB  = 8;
  localparam int X_MSB   = 7;
  localparam int X_LSB   = 6;
  localparam int Y_MSB   = 5;
  localparam int Y_LSB   = 4;
  localparam int D_MSB   = 3;
  localparam int D_LSB   = 0;

  // Packed view whose layout matches the bit positions above.
  typedef struct packed {
    logic [OP_MSB-OP_LSB:0] op;
    logic [X_MSB-X_LSB:0]   x;
    logic [Y_MSB-Y_LSB:0]   y;
    logic [D_MSB-D_LSB:0]   data;
  } instr_t;

  typedef enum logic [1:0] {
    I_IDLE    = 2'd0,
    I_ISSUE   = 2'd1,
    I_RELEASE = 2'd2
  } issue_state_e;

endpackage

// File: rtl/l2_instr_fifo.sv
// -----------------------------------------------------------------------------
// l2_instr_fifo -- DEPTH-entry instruction queue (DEPTH a power of 2).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (empties the queue)
//   push, din       write din when push and not full
//   pop             drop head entry when pop and not empty
//   full, empty     occupancy flags, derived from the registered count
//   head            oldest entry (valid when !empty)
//   count           number of entries held, 0..DEPTH
// A push while full is refused even if a pop happens on the same edge.
// -----------------------------------------------------------------------------
module l2_instr_fifo
  import l2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  instr_t                   din,
  output logic                     full,
  output logic                     empty,
  output instr_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  instr_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/l2_issue.sv
// -----------------------------------------------------------------------------
// l2_issue -- queues instructions and hands them one at a time to a
// downstream control state machine, using an execute/DONE handshake.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   instr_in[9:0]       {opcode, X addr, Y addr, immediate}
//   instr_valid         producer offers instr_in
//   instr_ready         queue not full (transfer when valid && ready)
//   sm_state[3:0]       downstream state code (0 = idle, 8 = done)
//   step                only with L2_ISSUE_STEP_EN: gates each issue
//   execute             registered go signal to the downstream machine
//   operation, addr_x,
//   addr_y, data_out    registered fields of the issued instruction
//   busy                queue non-empty or an issue in progress
//   retired[7:0]        completed-instruction count, wraps 255 -> 0
// Build option: define L2_ISSUE_STEP_EN to add the step input; each issue
// then needs step high in the cycle it would otherwise start. A step seen
// at any other time is simply ignored.
// -----------------------------------------------------------------------------
module l2_issue
  import l2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr_in,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [3:0]           sm_state,
`ifdef L2_ISSUE_STEP_EN
  input  logic                 step,
`endif
  output logic                 execute,
  output logic [1:0]           operation,
  output logic [1:0]           addr_x,
  output logic [1:0]           addr_y,
  output logic [3:0]           data_out,
  output logic                 busy,
  output logic [7:0]           retired
);

  issue_state_e           state;
  issue_state_e           state_next;
  logic                   start_issue;
  logic                   finish_issue;
  logic                   step_ok;
  logic                   full;
  logic                   empty;
  instr_t                 head;
  logic [$clog2(DEPTH):0] count;

`ifdef L2_ISSUE_STEP_EN
  assign step_ok = step;
`else
  assign step_ok = 1'b1;
`endif

  l2_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (instr_valid && instr_ready),
    .pop   (finish_issue),
    .din   (instr_t'(instr_in)),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (count)
  );

  assign instr_ready = !full;
  assign busy        = (state != I_IDLE) || (count != '0);

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next   = state;
    start_issue  = 1'b0;
    finish_issue = 1'b0;
    case (state)
      I_IDLE: begin
        if (!empty && sm_state == SM_IDLE && step_ok) begin
          state_next  = I_ISSUE;
          start_issue = 1'b1;
        end
      end
      I_ISSUE: begin
        if (sm_state == SM_DONE) begin
          state_next   = I_RELEASE;
          finish_issue = 1'b1;
        end
      end
      I_RELEASE: begin
        // Returning to idle takes this edge; a new issue starts no earlier
        // than the next one.
        if (sm_state == SM_IDLE) state_next = I_IDLE;
      end
      default: state_next = I_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= I_IDLE;
    else        state <= state_next;
  end

  // Fields load only on issue, so they stay put through I_ISSUE/I_RELEASE
  // and keep their last value while the queue is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      execute   <= 1'b0;
      operation <= '0;
      addr_x    <= '0;
      addr_y    <= '0;
      data_out  <= '0;
      retired   <= '0;
    end else begin
      if (start_issue) begin
        execute   <= 1'b1;
        operation <= head.op;
        addr_x    <= head.x;
        addr_y    <= head.y;
        data_out  <= head.data;
      end
      if (finish_issue) begin
        execute <= 1'b0;
        retired <= retired + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_l2_issue.sv
// -----------------------------------------------------------------------------
// tb_l2_issue -- self-checking bench for l2_issue (DEPTH = 4).
// Every cycle is compared against a queue-based reference model; directed
// tables and sequences add fixed expectations for the documented scenarios.
// -----------------------------------------------------------------------------
module tb_l2_issue;
  import l2_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] instr_in = '0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] sm_state = '0;
  logic       execute;
  logic [1:0] operation, addr_x, addr_y;
  logic [3:0] data_out;
  logic       busy;
  logic [7:0] retired;
`ifdef L2_ISSUE_STEP_EN
  logic       step = 1'b1;
`endif

  l2_issue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .sm_state    (sm_state),
`ifdef L2_ISSUE_STEP_EN
    .step        (step),
`endif
    .execute     (execute),
    .operation   (operation),
    .addr_x      (addr_x),
    .addr_y      (addr_y),
    .data_out    (data_out),
    .busy        (busy),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: a queue of pending instructions, plus "an instruction
  // is out" and "waiting for the machine to go idle again" flags.
  logic [9:0] mq[$];
  bit         m_out = 0;
  bit         m_wait_idle = 0;
  logic       m_exec = 0;
  logic [9:0] m_fields = '0;
  int         m_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit step_seen();
`ifdef L2_ISSUE_STEP_EN
    return step === 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_edge();
    bit acc;
    if (rst_n === 1'b0) begin
      mq.delete();
      m_out = 0; m_wait_idle = 0; m_exec = 0; m_fields = '0; m_ret = 0;
      return;
    end
    acc = instr_valid && (mq.size() < DEPTH);
    if (m_out && !m_wait_idle) begin
      if (sm_state == SM_DONE) begin
        void'(mq.pop_front());
        m_ret = (m_ret + 1) % 256;
        m_exec = 0;
        m_wait_idle = 1;
      end
    end else if (m_out) begin
      if (sm_state == SM_IDLE) begin
        m_out = 0;
        m_wait_idle = 0;
      end
    end else if (mq.size() != 0 && sm_state == SM_IDLE && step_seen()) begin
      m_fields = mq[0];
      m_exec = 1;
      m_out = 1;
    end
    if (acc) mq.push_back(instr_in);
  endtask

  task automatic compare_model();
    logic       e_ready, e_busy;
    logic [9:0] got_f;
    got_f   = {operation, addr_x, addr_y, data_out};
    e_ready = (mq.size() < DEPTH);
    e_busy  = m_out || (mq.size() != 0);
    n_vec++;
    if (instr_ready !== e_ready || busy !== e_busy || execute !== m_exec ||
        got_f !== m_fields || retired !== 8'(m_ret)) begin
      n_bad++;
      $display("FAIL model t=%0t: got rdy=%b busy=%b exe=%b f=%b ret=%0d, expected rdy=%b busy=%b exe=%b f=%b ret=%0d",
               $time, instr_ready, busy, execute, got_f, retired,
               e_ready, e_busy, m_exec, m_fields, m_ret);
    end
  endtask

  // Drive inputs mid-cycle, take one edge, then sample 1 ns later.
  task automatic tick(input logic v, input logic [9:0] ins, input logic [3:0] sm, input logic rn);
    @(negedge clk);
    instr_valid = v;
    instr_in    = ins;
    sm_state    = sm;
    rst_n       = rn;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic       v;
    logic [9:0] ins;
    logic [3:0] sm;
    logic       rn;
    logic       e_exec;
    logic [5:0] e_opxy;
    logic       e_ready;
    logic       e_busy;
    logic [7:0] e_ret;
  } vec_t;

  vec_t tbl[8];

  initial begin
    // Single instruction 11_01_10_0000 with sm_state 0->2->4->7->8->0.
    tbl[0] = '{1'b0, 10'b0, 4'd0, 1'b0, 1'b0, 6'b00_00_00, 1'b1, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 10'b11_01_10_0000, 4'd0, 1'b1, 1'b0, 6'b00_00_00, 1'b1, 1'b1, 8'd0};
    tbl[2] = '{1'b0, 10'b0, 4'd0, 1'b1, 1'b1, 6'b11_01_10, 1'b1, 1'b1, 8'd0};
    tbl[3] = '{1'b0, 10'b0, 4'd2, 1'b1, 1'b1, 6'b11_01_10, 1'b1, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 10'b0, 4'd4, 1'b1, 1'b1, 6'b11_01_10, 1'b1, 1'b1, 8'd0};
    tbl[5] = '{1'b0, 10'b0, 4'd7, 1'b1, 1'b1, 6'b11_01_10, 1'b1, 1'b1, 8'd0};
    tbl[6] = '{1'b0, 10'b0, 4'd8, 1'b1, 1'b0, 6'b11_01_10, 1'b1, 1'b1, 8'd1};
    tbl[7] = '{1'b0, 10'b0, 4'd0, 1'b1, 1'b0, 6'b11_01_10, 1'b1, 1'b0, 8'd1};

    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].v, tbl[i].ins, tbl[i].sm, tbl[i].rn);
      check($sformatf("tbl[%0d]", i),
            {execute, operation, addr_x, addr_y, instr_ready, busy, retired},
            {tbl[i].e_exec, tbl[i].e_opxy, tbl[i].e_ready, tbl[i].e_busy, tbl[i].e_ret});
    end

    // Full queue: 4 back-to-back pushes fill it; the 5th waits for a pop.
    tick(0, '0, 0, 0);
    for (int k = 0; k < 4; k++) tick(1, 10'(k + 1), 0, 1);
    check("full_ready", instr_ready, 0);
    tick(1, 10'h3c5, 0, 1);
    tick(1, 10'h3c5, 0, 1);
    check("full_hold", instr_ready, 0);
    tick(1, 10'h3c5, 8, 1);  // pop edge: push still refused
    check("ready_after_pop", instr_ready, 1);
    tick(1, 10'h3c5, 0, 1);  // 5th accepted now
    check("fifth_accepted", instr_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, '0, 0, 1);
      tick(0, '0, 8, 1);
      tick(0, '0, 0, 1);
    end
    check("full_drained", busy, 0);

    // Order: LOAD d=5, MV, SUB, ADD issue in order.
    tick(0, '0, 0, 0);
    tick(1, 10'b00_00_00_0101, 3, 1);
    tick(1, 10'b01_01_01_0001, 3, 1);
    tick(1, 10'b10_10_10_0010, 3, 1);
    tick(1, 10'b11_11_11_0011, 3, 1);
    check("order_wait", execute, 0);
    for (int k = 0; k < 4; k++) begin
      tick(0, '0, 0, 1);
      check($sformatf("order_exec%0d", k), execute, 1);
      check($sformatf("order_op%0d", k), operation, 32'(k));
      if (k == 0) check("order_data", data_out, 5);
      tick(0, '0, 8, 1);
      tick(0, '0, 0, 1);
    end

    // Reset mid-issue with 3 entries queued.
    tick(0, '0, 0, 0);
    for (int k = 0; k < 4; k++) tick(1, 10'(k + 16), 0, 1);
    check("mid_exec", execute, 1);
    tick(0, '0, 8, 0);
    check("rst_exec", execute, 0);
    check("rst_ret", retired, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", instr_ready, 1);
    tick(1, 10'h2a7, 3, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, '0, 3, 1);
      check($sformatf("no_issue%0d", k), execute, 0);
    end
    tick(0, '0, 0, 1);
    check("issue_at_idle", execute, 1);
    tick(0, '0, 8, 1);
    tick(0, '0, 0, 1);

    // Retired counter wrap.
    tick(0, '0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      tick(1, 10'($urandom), 3, 1);
      tick(0, '0, 0, 1);
      tick(0, '0, 8, 1);
      tick(0, '0, 0, 1);
      if (i == 254) check("ret_255", retired, 255);
    end
    check("ret_wrap", retired, 0);

`ifdef L2_ISSUE_STEP_EN
    // Step gating: nothing issues without step; one pulse issues once.
    step = 1'b0;
    tick(0, '0, 0, 0);
    tick(1, 10'h155, 0, 1);
    tick(1, 10'h2aa, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, '0, 0, 1);
      check($sformatf("step_wait%0d", k), execute, 0);
    end
    step = 1'b1;
    tick(0, '0, 0, 1);
    step = 1'b0;
    check("step_issue", execute, 1);
    check("step_op", operation, 1);
    tick(0, '0, 8, 1);
    tick(0, '0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(0, '0, 0, 1);
      check($sformatf("step_once%0d", k), execute, 0);
    end
    check("step_busy", busy, 1);
`endif

    // Randomized traffic against the model.
    tick(0, '0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] sm;
      int r;
      r = $urandom_range(0, 5);
      if (r < 2)      sm = SM_IDLE;
      else if (r < 4) sm = SM_DONE;
      else            sm = 4'($urandom);
`ifdef L2_ISSUE_STEP_EN
      step = ($urandom_range(0, 3) != 0);
`endif
      tick(1'($urandom), 10'($urandom), sm, ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
